vrf_seq: RTL and testbench
==========================

Name: vrf_seq

Overview:
- Sequencer for the 256 x 32 vector register RAM, organised as 32 VRs x 8 elements; element address = {vr[4:0], elem[2:0]}.
- Accepts one element-wise vector command: vd = f(vs1, vs2), with vl elements.
- Drives the RAM dual read ports element by element and streams operand pairs to the execution lane.
- Writes lane results back to vd, then signals completion.

Parameters:
- DW, 32, element data width
- AW, 8, RAM address width (VR index 5 bits + element index 3 bits)
- ELEMS, 8, elements per VR; vl saturates at this value

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, can accept a command
- cmd_vs1  in  5  source VR A
- cmd_vs2  in  5  source VR B
- cmd_vd  in  5  destination VR
- cmd_vl  in  4  element count, 0..8 (values above 8 are clamped to 8)
- ram_re  out  1  RAM read enable
- ram_raddr1  out  AW  read address A
- ram_raddr2  out  AW  read address B
- ram_rdataA  in  DW  registered read data A (held by the RAM while ram_re=0)
- ram_rdataB  in  DW  registered read data B
- ram_we  out  1  RAM write enable
- ram_waddr  out  AW  write address
- ram_wdata  out  DW  write data
- op_valid  out  1  operand pair valid
- op_ready  in  1  lane accepts the operand pair
- op_a  out  DW  operand A (= ram_rdataA)
- op_b  out  DW  operand B (= ram_rdataB)
- op_idx  out  3  element index of the current pair
- op_last  out  1  current pair is element vl-1
- res_valid  in  1  lane result valid
- res_ready  out  1  result accepted
- res_data  in  DW  lane result
- done  out  1  one-cycle pulse: command complete

Behaviour:
- Reset values: state IDLE; rd_cnt=0, wr_cnt=0, op_valid=0, op_idx=0, done=0, latched command fields 0.
- Reset values of combinational outputs: ram_re=0, ram_we=0, all addresses 0, res_ready=0, cmd_ready=1.
- States: IDLE, RUN.
- Command accept: cmd_valid && cmd_ready, in IDLE only.
  - Latch vs1, vs2, vd and vl_eff = min(cmd_vl, 8).
  - Clear rd_cnt and wr_cnt.
  - vl_eff>0: go to RUN.
  - vl_eff=0: stay in IDLE, done=1 next cycle, no RAM access.
- cmd_ready = (state==IDLE).
- Read issue (combinational): ram_re = RUN && rd_cnt<vl_eff && (!op_valid || op_ready).
  - ram_raddr1 = {vs1, rd_cnt[2:0]}; ram_raddr2 = {vs2, rd_cnt[2:0]}.
  - rd_cnt increments on every ram_re.
- Operand stage: on ram_re, next cycle op_valid=1, op_idx=rd_cnt, op_last=(rd_cnt==vl_eff-1).
  - If op_ready is seen with no new ram_re, next cycle op_valid=0.
- Stall: while op_valid && !op_ready, ram_re stays 0, so the RAM holds op_a/op_b stable.
- Latency: accept in cycle 0, first ram_re in cycle 1, first op_valid in cycle 2. Sustained rate is 1 element per cycle with op_ready=1.
- Writeback: res_ready = RUN && wr_cnt<vl_eff.
  - ram_we = res_valid && res_ready; ram_waddr = {vd, wr_cnt[2:0]}; ram_wdata = res_data (combinational pass-through).
  - wr_cnt increments on every write.
- Completion: a write with wr_cnt==vl_eff-1 moves to IDLE; done=1 in the next cycle.
  - A new command may be accepted in the done cycle.
- Results are written in arrival order. The lane returns results in element order; results are not tagged.
- Read/write overlap (e.g. vd==vs1):
  - Write index is always below read index, so there is no RAW hazard for element-wise ops.
  - A same-cycle same-address read returns the old value.
- res_valid while in IDLE: ignored, no write.
- op_ready while op_valid=0: ignored.
- Reset mid-command: everything returns immediately to the reset values. No further RAM reads or writes; done is not pulsed.

Decomposition:
- Shared package vrf_pkg:
  - constants NUM_VR=32, ELEMS=8, VR_W=5, EL_W=3, AW=8, DW=32
  - state enum vrf_seq_state_t {IDLE, RUN}
  - function vrf_addr(vr, elem) returning {vr, elem}
- No sub-module needed. The read and write element counters are small enough to stay inline.

Test Plan:
- Basic add: VR1 elements = 1..8, VR2 elements = 10..80, cmd vs1=1, vs2=2, vd=3, vl=8; lane returns a+b with op_ready=1.
  - ram_raddr1 = 0x08..0x0F.
  - op_valid begins 2 cycles after accept; op_last at idx 7.
  - ram_waddr = 0x18..0x1F with data 11..88; done pulses once.
- Backpressure: same command, op_ready low for 3 cycles at idx 2.
  - ram_re=0 during the stall; op_a/op_b/op_idx held at element 2.
  - No element is skipped or duplicated; done occurs after 8 writes.
- vl=0 and vl=12: vl=0 gives done the next cycle with zero ram_re/ram_we.
  - vl=12 is clamped: exactly 8 reads/writes, last ram_waddr = {vd,3'd7}.
- In-place op: vs1=vd=5, vs2=6, vl=8, lane returns a+1.
  - Each element is read before it is overwritten; VR5 ends at old+1 for all 8 elements.
- Reset mid-op: assert rst after 4 writes of vl=8.
  - Outputs go to reset values immediately; no done; cmd_ready=1 once rst is released.
  - A new command then runs from element 0.
- Stray results: res_valid=1 while in IDLE, and extra results after the 8th write.
  - res_ready=0 and ram_we=0; no RAM contents change.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared constants, state type and address helper for the vector register file sequencer.
// The RAM holds 32 VRs x 8 elements, addressed as {vr, elem}.
package vrf_pkg;

    localparam int NUM_VR = 32;
    localparam int ELEMS  = 8;
    localparam int VR_W   = 5;
    localparam int EL_W   = 3;
    localparam int AW     = 8;
    localparam int DW     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vrf_seq_state_t;

    function automatic logic [AW-1:0] vrf_addr(input logic [VR_W-1:0] vr,
                                               input logic [EL_W-1:0] elem);
        return {vr, elem};
    endfunction

endpackage

// File: rtl/vrf_seq.sv
// Element-wise vector command sequencer: reads vs1/vs2 element pairs from the
// dual-read RAM, streams them to the lane and writes lane results back to vd.
module vrf_seq #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int ELEMS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [4:0]                   cmd_vs1,
    input  logic [4:0]                   cmd_vs2,
    input  logic [4:0]                   cmd_vd,
    input  logic [3:0]                   cmd_vl,
    output logic                         ram_re,
    output logic [AW-1:0]                ram_raddr1,
    output logic [AW-1:0]                ram_raddr2,
    input  logic [DW-1:0]                ram_rdataA,
    input  logic [DW-1:0]                ram_rdataB,
    output logic                         ram_we,
    output logic [AW-1:0]                ram_waddr,
    output logic [DW-1:0]                ram_wdata,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [DW-1:0]                op_a,
    output logic [DW-1:0]                op_b,
    output logic [2:0]                   op_idx,
    output logic                         op_last,
    input  logic                         res_valid,
    output logic                         res_ready,
    input  logic [DW-1:0]                res_data,
    output logic                         done,
    output vrf_pkg::vrf_seq_state_t      dbg_state
);
    import vrf_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid is high and ready is low.

    vrf_seq_state_t state, state_nxt;

    logic [VR_W-1:0] vs1_q, vs2_q, vd_q;
    logic [3:0]      vl_q;
    logic [3:0]      rd_cnt, wr_cnt;
    logic [3:0]      vl_clamped;
    logic            accept;
    logic            last_write;

    assign vl_clamped = (cmd_vl > 4'(ELEMS)) ? 4'(ELEMS) : cmd_vl;
    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;

    // A read may only issue when the operand slot is free or being drained,
    // so the RAM output register doubles as the operand holding register.
    assign ram_re     = (state == RUN) && (rd_cnt < vl_q) && (!op_valid || op_ready);
    assign ram_raddr1 = vrf_addr(vs1_q, rd_cnt[EL_W-1:0]);
    assign ram_raddr2 = vrf_addr(vs2_q, rd_cnt[EL_W-1:0]);
    assign op_a       = ram_rdataA;
    assign op_b       = ram_rdataB;

    assign res_ready  = (state == RUN) && (wr_cnt < vl_q);
    assign ram_we     = res_valid && res_ready;
    assign ram_waddr  = vrf_addr(vd_q, wr_cnt[EL_W-1:0]);
    assign ram_wdata  = res_data;
    assign last_write = ram_we && (wr_cnt == vl_q - 4'd1);

    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (vl_clamped != 4'd0)) state_nxt = RUN;
            RUN:     if (last_write) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            vl_q     <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            op_valid <= 1'b0;
            op_idx   <= '0;
            op_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (accept && (vl_clamped == 4'd0)) || last_write;

            if (accept) begin
                vs1_q  <= cmd_vs1;
                vs2_q  <= cmd_vs2;
                vd_q   <= cmd_vd;
                vl_q   <= vl_clamped;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (ram_re) rd_cnt <= rd_cnt + 4'd1;
                if (ram_we) wr_cnt <= wr_cnt + 4'd1;
            end

            if (ram_re) begin
                op_valid <= 1'b1;
                op_idx   <= rd_cnt[EL_W-1:0];
                op_last  <= (rd_cnt == vl_q - 4'd1);
            end else if (op_valid && op_ready) begin
                op_valid <= 1'b0;
                op_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vrf_seq.sv
// Directed bench for vrf_seq: behavioural RAM and lane around the DUT, a model
// that derives expected operand pairs and writes from the command and RAM image.
module tb_vrf_seq;
    import vrf_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [4:0]      cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
    logic [3:0]      cmd_vl = '0;
    logic            ram_re;
    logic [AW-1:0]   ram_raddr1, ram_raddr2;
    logic [DW-1:0]   ram_rdataA = '0, ram_rdataB = '0;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic            op_valid;
    logic            op_ready;
    logic [DW-1:0]   op_a, op_b;
    logic [2:0]      op_idx;
    logic            op_last;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic [DW-1:0]   res_data = '0;
    logic            done;
    vrf_seq_state_t  dbg_state;

    vrf_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_vl(cmd_vl),
        .ram_re(ram_re), .ram_raddr1(ram_raddr1), .ram_raddr2(ram_raddr2),
        .ram_rdataA(ram_rdataA), .ram_rdataB(ram_rdataB),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_idx(op_idx), .op_last(op_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM ----------------
    logic [DW-1:0] ram [256];
    logic          preload = 1'b0;

    function automatic logic [DW-1:0] init_val(input int a);
        int vr, el;
        vr = a / 8;
        el = a % 8;
        if (vr == 1) return DW'(el + 1);
        if (vr == 2) return DW'(10 * (el + 1));
        if (vr == 5) return DW'(100 + el);
        if (vr == 6) return DW'(1000 + el);
        return DW'(a * 3 + 7);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) ram[a] <= init_val(a);
        end else begin
            if (ram_re) begin
                ram_rdataA <= ram[ram_raddr1];
                ram_rdataB <= ram[ram_raddr2];
            end
            if (ram_we) ram[ram_waddr] <= ram_wdata;
        end
    end

    // ---------------- behavioural lane ----------------
    logic [DW-1:0] lane_q[$];
    int            lane_mode = 0;   // 0: a+b, 1: a+1
    logic          stray_en = 1'b0;
    logic          stall_en = 1'b0;
    int            stall_used = 0;

    assign op_ready = !(stall_en && op_valid && (op_idx == 3'd2) && (stall_used < 3));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q.delete();
            res_valid  <= 1'b0;
            res_data   <= '0;
            stall_used <= 0;
        end else begin
            if (res_valid && res_ready && lane_q.size() > 0) void'(lane_q.pop_front());
            if (op_valid && op_ready) lane_q.push_back((lane_mode == 0) ? op_a + op_b : op_a + 1);
            res_valid <= (lane_q.size() > 0) || stray_en;
            res_data  <= (lane_q.size() > 0) ? lane_q[0] : 32'hDEAD_BEEF;
            if (!stall_en) stall_used <= 0;
            else if (op_valid && op_idx == 3'd2 && !op_ready) stall_used <= stall_used + 1;
        end
    end

    // ---------------- model + scoreboard ----------------
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    idx;
        logic          last;
    } op_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    op_t           exp_op_q[$];
    wr_t           exp_wr_q[$];
    logic [DW-1:0] ref_mem [256];
    op_t           e_op;
    wr_t           e_wr;
    logic          m_busy = 1'b0;
    logic          exp_done_next = 1'b0;
    logic          exp_re;
    logic [4:0]    m_vs1 = '0, m_vs2 = '0;
    int            m_vl = 0, vl_eff = 0;
    int            rd_seen = 0, wr_seen = 0;
    int            re_count = 0, we_count = 0, stall_re = 0, idx2_cycles = 0;
    int            acc_cyc = 0, first_re_cyc = -1, first_op_cyc = -1, done_cyc = 0;
    int            done_count = 0;
    logic [AW-1:0] first_raddr1 = '0, last_waddr = '0;

    always @(negedge clk) begin
        if (preload) for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        if (rst) begin
            exp_op_q.delete();
            exp_wr_q.delete();
            m_busy = 1'b0;
            exp_done_next = 1'b0;
            chk("rst_outs", {cmd_ready, ram_re, ram_we, op_valid, res_ready, done}, 6'b100000);
        end else begin
            chk("done", done, exp_done_next);
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            exp_done_next = 1'b0;
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("res_ready", res_ready, m_busy && (wr_seen < m_vl));
            exp_re = m_busy && (rd_seen < m_vl) && (!op_valid || op_ready);
            chk("ram_re", ram_re, exp_re);

            if (op_valid) begin
                if (exp_op_q.size() == 0) begin
                    chk("op_unexpected", 1, 0);
                end else begin
                    e_op = exp_op_q[0];
                    chk("op_a", op_a, e_op.a);
                    chk("op_b", op_b, e_op.b);
                    chk("op_idx", op_idx, e_op.idx);
                    chk("op_last", op_last, e_op.last);
                    if (op_idx == 3'd2) idx2_cycles++;
                    if (first_op_cyc < 0) first_op_cyc = cyc;
                    if (op_ready) void'(exp_op_q.pop_front());
                end
            end

            if (ram_re) begin
                chk("raddr1", ram_raddr1, {m_vs1, 3'(rd_seen)});
                chk("raddr2", ram_raddr2, {m_vs2, 3'(rd_seen)});
                if (first_re_cyc < 0) begin
                    first_re_cyc = cyc;
                    first_raddr1 = ram_raddr1;
                end
                if (op_valid && !op_ready) stall_re++;
                rd_seen++;
                re_count++;
            end

            if (ram_we) begin
                we_count++;
                last_waddr = ram_waddr;
                if (exp_wr_q.size() == 0) begin
                    chk("we_unexpected", 1, 0);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    chk("waddr", ram_waddr, e_wr.addr);
                    chk("wdata", ram_wdata, e_wr.data);
                    ref_mem[e_wr.addr] = e_wr.data;
                    wr_seen++;
                    if (exp_wr_q.size() == 0 && m_busy) begin
                        m_busy = 1'b0;
                        exp_done_next = 1'b1;
                    end
                end
            end

            if (cmd_valid && cmd_ready) begin
                vl_eff = (cmd_vl > 4'd8) ? 8 : int'(cmd_vl);
                m_vs1 = cmd_vs1;
                m_vs2 = cmd_vs2;
                m_vl = vl_eff;
                rd_seen = 0; wr_seen = 0; re_count = 0; we_count = 0;
                stall_re = 0; idx2_cycles = 0;
                acc_cyc = cyc; first_re_cyc = -1; first_op_cyc = -1;
                for (int i = 0; i < vl_eff; i++) begin
                    e_op.a    = ref_mem[{cmd_vs1, 3'(i)}];
                    e_op.b    = ref_mem[{cmd_vs2, 3'(i)}];
                    e_op.idx  = 3'(i);
                    e_op.last = (i == vl_eff - 1);
                    exp_op_q.push_back(e_op);
                    e_wr.addr = {cmd_vd, 3'(i)};
                    e_wr.data = (lane_mode == 0) ? e_op.a + e_op.b : e_op.a + 1;
                    exp_wr_q.push_back(e_wr);
                end
                if (vl_eff == 0) exp_done_next = 1'b1;
                else m_busy = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [3:0] vl);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_vs1 = s1; cmd_vs2 = s2; cmd_vd = d; cmd_vl = vl;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [3:0] vl);
        int d0, n;
        d0 = done_count;
        issue(s1, s2, d, vl);
        n = 0;
        while (done_count == d0 && n < 300) begin
            tick(1);
            n++;
        end
        if (done_count == d0) chk("done_timeout", 0, 1);
        tick(1);
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== ref_mem[a]) bad++;
        chk(name, bad, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        rst = 1'b1;
        preload = 1'b1;
        tick(3);
        preload = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("rst_raddr1", ram_raddr1, 8'h00);
        chk("rst_raddr2", ram_raddr2, 8'h00);
        chk("rst_waddr", ram_waddr, 8'h00);
        chk("rst_op_idx", op_idx, 3'd0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // stray results in IDLE are never written
        stray_en = 1'b1;
        tick(3);
        chk("stray_idle_res_ready", res_ready, 1'b0);
        chk("stray_idle_we", ram_we, 1'b0);
        stray_en = 1'b0;
        tick(3);
        mem_check("mem_stray_idle");

        // basic add VR3 = VR1 + VR2
        lane_mode = 0;
        run_cmd(5'd1, 5'd2, 5'd3, 4'd8);
        chk("basic_lat_re", first_re_cyc - acc_cyc, 1);
        chk("basic_lat_op", first_op_cyc - acc_cyc, 2);
        chk("basic_first_raddr1", first_raddr1, 8'h08);
        chk("basic_writes", we_count, 8);
        chk("basic_last_waddr", last_waddr, 8'h1F);
        for (int i = 0; i < 8; i++) chk("basic_vr3", ram[8'h18 + i], 32'(11 * (i + 1)));
        mem_check("mem_basic");

        // extra results after the last write
        d0 = done_count;
        stray_en = 1'b1;
        tick(4);
        chk("stray_after_res_ready", res_ready, 1'b0);
        stray_en = 1'b0;
        tick(3);
        chk("stray_after_no_done", done_count, d0);
        mem_check("mem_stray_after");

        // backpressure at element 2
        stall_en = 1'b1;
        run_cmd(5'd1, 5'd2, 5'd3, 4'd8);
        stall_en = 1'b0;
        chk("bp_re_during_stall", stall_re, 0);
        chk("bp_idx2_cycles", idx2_cycles, 4);
        chk("bp_reads", re_count, 8);
        chk("bp_writes", we_count, 8);
        mem_check("mem_bp");

        // vl = 0
        run_cmd(5'd1, 5'd2, 5'd4, 4'd0);
        chk("vl0_done_lat", done_cyc - acc_cyc, 1);
        chk("vl0_reads", re_count, 0);
        chk("vl0_writes", we_count, 0);

        // vl = 12 clamps to 8
        run_cmd(5'd2, 5'd1, 5'd7, 4'd12);
        chk("vl12_reads", re_count, 8);
        chk("vl12_writes", we_count, 8);
        chk("vl12_last_waddr", last_waddr, 8'h3F);
        mem_check("mem_vl12");

        // in-place VR5 = VR5 + 1
        lane_mode = 1;
        run_cmd(5'd5, 5'd6, 5'd5, 4'd8);
        for (int i = 0; i < 8; i++) chk("inplace_vr5", ram[8'h28 + i], 32'(101 + i));
        mem_check("mem_inplace");

        // reset after 4 writes
        lane_mode = 0;
        issue(5'd1, 5'd2, 5'd9, 4'd8);
        for (int n = 0; n < 100 && we_count < 4; n++) tick(1);
        chk("abort_reached_4", we_count, 4);
        d0 = done_count;
        rst = 1'b1;
        #1;
        chk("abort_ram_re", ram_re, 1'b0);
        chk("abort_ram_we", ram_we, 1'b0);
        chk("abort_op_valid", op_valid, 1'b0);
        chk("abort_res_ready", res_ready, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_raddr1", ram_raddr1, 8'h00);
        chk("abort_waddr", ram_waddr, 8'h00);
        chk("abort_op_idx", op_idx, 3'd0);
        tick(3);
        rst = 1'b0;
        chk("abort_ready_after", cmd_ready, 1'b1);
        tick(3);
        chk("abort_no_done", done_count, d0);
        mem_check("mem_abort");
        run_cmd(5'd1, 5'd2, 5'd9, 4'd8);
        chk("rerun_first_raddr1", first_raddr1, 8'h08);
        chk("rerun_writes", we_count, 8);
        for (int i = 0; i < 8; i++) chk("rerun_vr9", ram[8'h48 + i], 32'(11 * (i + 1)));
        mem_check("mem_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
